// File: rtl/cla_pkg.sv
// Shared constants and the stage-register record for the pipelined lookahead adder.
package cla_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultGroup = 4;
    // Record fields are sized for the widest supported adder; narrower builds use the low bits.
    localparam int unsigned MaxWidth = 64;

    typedef struct packed {
        logic                valid;
        logic                carry;
        logic [MaxWidth-1:0] sum;
        logic [MaxWidth-1:0] a;
        logic [MaxWidth-1:0] b;
    } stage_t;

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice with group generate/propagate outputs.
module cla_group #(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             c_out,
    output logic             g,
    output logic             p
);

    logic [GROUP-1:0] gen;
    logic [GROUP-1:0] prop;
    logic [GROUP:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    always_comb begin
        carry    = '0;
        carry[0] = c_in;
        g        = 1'b0;
        p        = 1'b1;
        for (int i = 0; i < int'(GROUP); i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
            g          = gen[i] | (prop[i] & g);
            p          = p & prop[i];
        end
        s     = prop ^ carry[GROUP-1:0];
        c_out = carry[GROUP];
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder, one GROUP-bit slice per stage, valid/ready handshake.
// Define CLA_OVF_EN to add the registered two's-complement overflow output ovf.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned GROUP = DefaultGroup
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NSTG = WIDTH / GROUP;

    stage_t           src     [NSTG];
    stage_t           stage_d [NSTG];
    stage_t           stage_q [NSTG];
    logic [GROUP-1:0] grp_s   [NSTG];
    logic             grp_co  [NSTG];
    logic             adv;

    assign adv      = !stage_q[NSTG-1].valid || out_ready;
    assign in_ready = adv;

    // Operands travel right-shifted so the group a stage works on always sits at bit 0.
    always_comb begin
        src[0]       = '0;
        src[0].valid = in_valid;
        src[0].carry = c_in;
        src[0].a     = MaxWidth'(a);
        src[0].b     = MaxWidth'(b);
        for (int k = 1; k < int'(NSTG); k++) begin
            src[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < int'(NSTG); k++) begin : g_stage
        logic grp_g;
        logic grp_p;
        logic unused_gp;

        cla_group #(
            .GROUP(GROUP)
        ) u_group (
            .a    (src[k].a[GROUP-1:0]),
            .b    (src[k].b[GROUP-1:0]),
            .c_in (src[k].carry),
            .s    (grp_s[k]),
            .c_out(grp_co[k]),
            .g    (grp_g),
            .p    (grp_p)
        );

        assign unused_gp = grp_g ^ grp_p;
    end

    always_comb begin
        for (int k = 0; k < int'(NSTG); k++) begin
            stage_d[k].valid = src[k].valid;
            stage_d[k].carry = grp_co[k];
            stage_d[k].a     = src[k].a >> GROUP;
            stage_d[k].b     = src[k].b >> GROUP;
            stage_d[k].sum   = src[k].sum | (MaxWidth'(grp_s[k]) << (k * GROUP));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NSTG); k++) begin
                stage_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < int'(NSTG); k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[NSTG-1].valid;
    assign s         = stage_q[NSTG-1].sum[WIDTH-1:0];
    assign c_out     = stage_q[NSTG-1].carry;

    // Last-stage operand remainders are always zero; only the low sum bits leave the block.
    logic unused_last;
    assign unused_last = ^{stage_q[NSTG-1].a, stage_q[NSTG-1].b, stage_q[NSTG-1].sum};

`ifdef CLA_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB is recovered as a ^ b ^ s at that bit.
    assign ovf_d = src[NSTG-1].a[GROUP-1] ^ src[NSTG-1].b[GROUP-1]
                 ^ grp_s[NSTG-1][GROUP-1] ^ grp_co[NSTG-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (16-bit, 4-bit groups); covers ovf when CLA_OVF_EN.
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        c_out;
`ifdef CLA_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_in  = 0;
    int n_out = 0;
    int last_lat = 0;

    logic [17:0] exp_q [$];   // {ovf, c_out, s}
    int          acc_q [$];
    int          log_cyc [$];
    logic [15:0] log_s [$];
    logic        log_c [$];
    logic        log_o [$];

    cla_pipe_adder #(
        .WIDTH(16),
        .GROUP(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .c_out    (c_out)
`ifdef CLA_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference: plain unsigned and signed arithmetic on the operands.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
        logic [16:0] u;
        int          sr;
        u  = {1'b0, x} + {1'b0, y} + {16'b0, ci};
        sr = int'($signed(x)) + int'($signed(y)) + int'(ci);
        return {(sr > 32767) || (sr < -32768), u};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle: drive inputs on the falling edge, then check the handshakes of the next edge.
    task automatic beat(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic ordy);
        logic [17:0] e;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        c_in      = ic;
        out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", 32'(s), 32'(e[15:0]));
                chk("c_out", 32'(c_out), 32'(e[16]));
`ifdef CLA_OVF_EN
                chk("ovf", 32'(ovf), 32'(e[17]));
                log_o.push_back(ovf);
`endif
                last_lat = cyc - acc_q.pop_front();
                log_cyc.push_back(cyc);
                log_s.push_back(s);
                log_c.push_back(c_out);
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(ia, ib, ic));
            acc_q.push_back(cyc);
            n_in++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        end
        chk("drain empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_logs();
        log_cyc.delete();
        log_s.delete();
        log_c.delete();
        log_o.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;   // beat presented during reset must be discarded
        a         = 16'h00FF;
        b         = 16'h0F0F;
        out_ready = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        exp_q.delete();
        acc_q.delete();
        n_in  = 0;
        n_out = 0;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst s", 32'(s), 32'd0);
        chk("rst c_out", 32'(c_out), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
`ifdef CLA_OVF_EN
        chk("rst ovf", 32'(ovf), 32'd0);
`endif
    endtask

    logic [15:0] exp_b2b [4];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();

        // Carry ripples through every group; result after exactly four cycles.
        beat(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            chk("t31 out_valid", 32'(out_valid), 32'(i == 3));
        end
        chk("t31 s", 32'(s), 32'h0000);
        chk("t31 c_out", 32'(c_out), 32'd1);
        chk("t31 latency", 32'(last_lat), 32'd4);
        drain();

        // Back-to-back beats come out on consecutive cycles in order.
        clear_logs();
        exp_b2b = '{16'd2, 16'd4, 16'd6, 16'h5555};
        beat(1'b1, 16'd1, 16'd1, 1'b0, 1'b1);
        beat(1'b1, 16'd2, 16'd2, 1'b0, 1'b1);
        beat(1'b1, 16'd3, 16'd3, 1'b0, 1'b1);
        beat(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1);
        drain();
        chk("b2b count", 32'(log_s.size()), 32'd4);
        if (log_s.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("b2b s", 32'(log_s[i]), 32'(exp_b2b[i]));
            for (int i = 0; i < 3; i++) chk("b2b gap", 32'(log_cyc[i+1] - log_cyc[i]), 32'd1);
        end

        // Fill the pipe with out_ready low, stall three cycles, then release.
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 16'(16'h1000 * (i + 1) + 7), 16'(i * 3), 1'(i), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
            chk("stall in_ready", 32'(in_ready), 32'd0);
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall s", 32'(s), 32'(exp_q[0][15:0]));
            chk("stall c_out", 32'(c_out), 32'(exp_q[0][16]));
        end
        drain();
        chk("stall in=out", 32'(n_in), 32'(n_out));

        // Reset with beats in flight: nothing stale may emerge.
        for (int i = 0; i < 3; i++) beat(1'b1, 16'(i + 100), 16'(i + 200), 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            chk("post-rst out_valid", 32'(out_valid), 32'd0);
        end

`ifdef CLA_OVF_EN
        clear_logs();
        beat(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        beat(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b1);
        beat(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1);
        drain();
        chk("ovf count", 32'(log_o.size()), 32'd3);
        if (log_o.size() == 3) begin
            chk("ovf 7fff+1", 32'(log_o[0]), 32'd1);
            chk("ovf 8000+ffff", 32'(log_o[1]), 32'd1);
            chk("c_out 8000+ffff", 32'(log_c[1]), 32'd1);
            chk("ovf 1234+4321", 32'(log_o[2]), 32'd0);
        end
`endif

        // Random traffic with random source and sink throttling.
        n_in  = 0;
        n_out = 0;
        for (int i = 0; i < 1000; i++) begin
            beat(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
        end
        drain();
        chk("random in=out", 32'(n_in), 32'(n_out));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
